// File: rtl/pfxdiff.sv
// pfxdiff: recovers an element vector from its inclusive prefix sums, LANES adjacent differences per cycle.
module pfxdiff #(
  parameter int IWIDTH = 8,
  parameter int V_LEN  = 16,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [V_LEN*IWIDTH-1:0]   ivec,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [V_LEN*IWIDTH-1:0]   ovec
);
  localparam int N  = V_LEN / LANES;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int W  = V_LEN * IWIDTH;
  typedef enum logic [1:0] {IDLE, DIFF, HOLD} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  copy_q, copy_d, ovec_q, ovec_d, prev;
  logic          valid_q, valid_d;
  // Element k of prev is copy[k-1], with zero below element 0 so lane 0 passes straight through.
  assign prev = copy_q << IWIDTH;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    copy_d  = copy_q;
    ovec_d  = ovec_q;
    valid_d = valid_q;
    if (state_q == IDLE && valid_in) begin
      copy_d  = ivec;
      idx_d   = '0;
      state_d = DIFF;
    end
    if (state_q == DIFF) begin
      for (int l = 0; l < LANES; l++)
        ovec_d[(int'(idx_q)*LANES+l)*IWIDTH +: IWIDTH] =
          copy_q[(int'(idx_q)*LANES+l)*IWIDTH +: IWIDTH] - prev[(int'(idx_q)*LANES+l)*IWIDTH +: IWIDTH];
      idx_d = idx_q + IW'(1);
      if (int'(idx_q) == N-1) begin
        valid_d = 1'b1;
        state_d = HOLD;
      end
    end
    if (state_q == HOLD && ready_out) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      copy_q  <= '0;
      ovec_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      copy_q  <= copy_d;
      ovec_q  <= ovec_d;
      valid_q <= valid_d;
    end
  end
  assign ready_in  = state_q == IDLE;
  assign valid_out = valid_q;
  assign ovec      = ovec_q;
endmodule
